usb_dma_bridge: RTL

Parametrised, bidirectional bridge between the FT1248 byte FIFOs and the DMA device port. It packs received USB bytes into DMA write words, or unpacks DMA read words into USB transmit bytes. Each transfer is CPU-programmed with direction, start address and byte length, and handles partial final words. It sits between usb_ft1248 and the DMA arbiter, with control and status registers owned by the CPU bus slave.

---
 rtl/usb_dma_pkg.sv | 18 +
 rtl/usb_dma_shifter.sv | 55 +++++
 rtl/usb_dma_bridge.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/usb_dma_pkg.sv
// Shared types for the USB <-> DMA bridge: FSM state encoding and transfer direction.
package usb_dma_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WRITE = 3'd2,
        S_READ  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } e_state;

    typedef enum logic {
        DIR_USB_TO_MEM = 1'b0,
        DIR_MEM_TO_USB = 1'b1
    } e_direction;

endpackage

// File: rtl/usb_dma_shifter.sv
// Big-endian byte word register shared by the pack (USB->memory) and unpack
// (memory->USB) paths: lane fill with byte enables, parallel load, MSB shift-out.
module usb_dma_shifter #(
    parameter int DATA_BYTES  = 2,
    parameter int COUNT_WIDTH = $clog2(DATA_BYTES + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      load,
    input  logic [8*DATA_BYTES-1:0]   load_data,
    input  logic                      put,
    input  logic [7:0]                put_byte,
    input  logic                      pop,
    output logic [8*DATA_BYTES-1:0]   data,
    output logic [DATA_BYTES-1:0]     mask,
    output logic [COUNT_WIDTH-1:0]    count,
    output logic [7:0]                head
);

    assign head = data[8*DATA_BYTES-1 -: 8];

    // Word, lane-enable and byte-count register; count is the next free lane from the MSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data  <= {(8*DATA_BYTES){1'b0}};
            mask  <= {DATA_BYTES{1'b0}};
            count <= {COUNT_WIDTH{1'b0}};
        end else if (clear) begin
            data  <= {(8*DATA_BYTES){1'b0}};
            mask  <= {DATA_BYTES{1'b0}};
            count <= {COUNT_WIDTH{1'b0}};
        end else if (load) begin
            data  <= load_data;
            mask  <= {DATA_BYTES{1'b0}};
            count <= {COUNT_WIDTH{1'b0}};
        end else if (put) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                if (count == COUNT_WIDTH'(i)) begin
                    data[8*(DATA_BYTES-1-i) +: 8] <= put_byte;
                    mask[DATA_BYTES-1-i]          <= 1'b1;
                end
            end
            count <= count + COUNT_WIDTH'(1);
        end else if (pop) begin
            data  <= data << 4'd8;
            count <= count + COUNT_WIDTH'(1);
        end else begin
            data  <= data;
            mask  <= mask;
            count <= count;
        end
    end

endmodule

// File: rtl/usb_dma_bridge.sv
// Bidirectional FT1248 byte FIFO <-> DMA word bridge. Packs RX bytes into DMA
// writes or unpacks DMA reads into TX bytes for a CPU-programmed byte length.
module usb_dma_bridge
    import usb_dma_pkg::*;
#(
    parameter int DATA_BYTES = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 24
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      direction,
    input  logic [ADDR_WIDTH-1:0]     start_address,
    input  logic [LEN_WIDTH-1:0]      length,
    output logic                      busy,
    output logic                      done,
    output logic [LEN_WIDTH-1:0]      remaining,
    input  logic                      rx_empty,
    output logic                      rx_read,
    input  logic [7:0]                rx_rdata,
    input  logic                      tx_full,
    output logic                      tx_write,
    output logic [7:0]                tx_wdata,
    output logic                      dma_request,
    input  logic                      dma_ack,
    output logic                      dma_write,
    output logic [ADDR_WIDTH-1:0]     dma_address,
    output logic [DATA_BYTES-1:0]     dma_wmask,
    output logic [8*DATA_BYTES-1:0]   dma_wdata,
    input  logic [8*DATA_BYTES-1:0]   dma_rdata
);

    localparam int CW = $clog2(DATA_BYTES + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(DATA_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(DATA_BYTES - 1));
    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO   = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE    = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    e_state         state_r;
    logic           stop_pending_r;
    logic           sh_clear_s;
    logic           sh_load_s;
    logic           sh_put_s;
    logic           sh_pop_s;
    logic [CW-1:0]  sh_count_s;
    logic [7:0]     sh_head_s;
    logic           word_end_s;
    logic           stopping_s;

    // A word is finished when every lane is used or the byte budget is exhausted.
    assign word_end_s = (sh_count_s == CW'(DATA_BYTES)) || (remaining == LEN_ZERO);
    assign stopping_s = stop || stop_pending_r;

    usb_dma_shifter #(
        .DATA_BYTES  (DATA_BYTES),
        .COUNT_WIDTH (CW)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .clear     (sh_clear_s),
        .load      (sh_load_s),
        .load_data (dma_rdata),
        .put       (sh_put_s),
        .put_byte  (rx_rdata),
        .pop       (sh_pop_s),
        .data      (dma_wdata),
        .mask      (dma_wmask),
        .count     (sh_count_s),
        .head      (sh_head_s)
    );

    // Shifter control; rx pops are spaced by a cycle so the FIFO head can advance.
    always_comb begin
        sh_clear_s = 1'b0;
        sh_load_s  = 1'b0;
        sh_put_s   = 1'b0;
        sh_pop_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start && !stop && (length != LEN_ZERO)) sh_clear_s = 1'b1;
                else                                        sh_clear_s = 1'b0;
            end
            S_FILL: begin
                if (!stop && !word_end_s && !rx_empty && !rx_read) sh_put_s = 1'b1;
                else                                               sh_put_s = 1'b0;
            end
            S_WRITE: begin
                if (dma_ack) sh_clear_s = 1'b1;
                else         sh_clear_s = 1'b0;
            end
            S_READ: begin
                if (dma_ack && !stopping_s) sh_load_s = 1'b1;
                else                        sh_load_s = 1'b0;
            end
            S_DRAIN: begin
                if (!stop && !word_end_s && !tx_full) sh_pop_s = 1'b1;
                else                                  sh_pop_s = 1'b0;
            end
            default: begin
                sh_clear_s = 1'b0;
            end
        endcase
    end

    // Transfer FSM and all registered bridge outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= S_IDLE;
            stop_pending_r <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            remaining      <= LEN_ZERO;
            rx_read        <= 1'b0;
            tx_write       <= 1'b0;
            tx_wdata       <= 8'h00;
            dma_request    <= 1'b0;
            dma_write      <= 1'b1;
            dma_address    <= {ADDR_WIDTH{1'b0}};
        end else begin
            done     <= 1'b0;
            rx_read  <= 1'b0;
            tx_write <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start && !stop) begin
                        if (length == LEN_ZERO) begin
                            done <= 1'b1;
                        end else begin
                            busy           <= 1'b1;
                            remaining      <= length;
                            dma_address    <= start_address & ALIGN_MASK;
                            stop_pending_r <= 1'b0;
                            if (e_direction'(direction) == DIR_MEM_TO_USB) begin
                                dma_request <= 1'b1;
                                dma_write   <= 1'b0;
                                state_r     <= S_READ;
                            end else begin
                                dma_write <= 1'b1;
                                state_r   <= S_FILL;
                            end
                        end
                    end
                end
                S_FILL: begin
                    if (stop) begin
                        state_r <= S_DONE;
                    end else if (word_end_s) begin
                        dma_request <= 1'b1;
                        dma_write   <= 1'b1;
                        state_r     <= S_WRITE;
                    end else if (sh_put_s) begin
                        rx_read   <= 1'b1;
                        remaining <= remaining - LEN_ONE;
                    end
                end
                S_WRITE: begin
                    if (stop) stop_pending_r <= 1'b1;
                    if (dma_ack) begin
                        dma_request <= 1'b0;
                        dma_address <= dma_address + ADDR_STEP;
                        if (stopping_s || (remaining == LEN_ZERO)) state_r <= S_DONE;
                        else                                       state_r <= S_FILL;
                    end
                end
                S_READ: begin
                    if (stop) stop_pending_r <= 1'b1;
                    // An aborted read still completes its bus cycle; the data is dropped.
                    if (dma_ack) begin
                        dma_request <= 1'b0;
                        dma_address <= dma_address + ADDR_STEP;
                        if (stopping_s) state_r <= S_DONE;
                        else            state_r <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (stop) begin
                        state_r <= S_DONE;
                    end else if (word_end_s) begin
                        if (remaining != LEN_ZERO) begin
                            dma_request <= 1'b1;
                            dma_write   <= 1'b0;
                            state_r     <= S_READ;
                        end else begin
                            state_r <= S_DONE;
                        end
                    end else if (sh_pop_s) begin
                        tx_write  <= 1'b1;
                        tx_wdata  <= sh_head_s;
                        remaining <= remaining - LEN_ONE;
                    end
                end
                S_DONE: begin
                    done           <= 1'b1;
                    busy           <= 1'b0;
                    stop_pending_r <= 1'b0;
                    state_r        <= S_IDLE;
                end
                default: begin
                    busy        <= 1'b0;
                    dma_request <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
